// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 core: steps the datapath through the initial
// AddRoundKey, NR-1 full rounds and a final round, and hands the ciphertext off via valid/ready.
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       in_ready,
    input  logic       hold,
    output logic       ld_state,
    output logic       key_ld,
    output logic       rnd_en,
    output logic       key_en,
    output logic       mix_bypass,
    output logic [3:0] round,
    output logic [7:0] rcon,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;
    localparam logic [2:0] ROUND = 3'd2;
    localparam logic [2:0] FINAL = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [3:0] LAST_FULL_RND = 4'(NR - 1);
    localparam logic [7:0] RCON_FIRST    = 8'h01;

    logic [2:0] state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return r[7] ? ({r[6:0], 1'b0} ^ 8'h1b) : {r[6:0], 1'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    round_d = 4'd0;
                    rcon_d  = RCON_FIRST;
                end
            end
            INIT: begin
                if (!hold) begin
                    state_d = ROUND;
                    round_d = 4'd1;
                    rcon_d  = RCON_FIRST;
                end
            end
            ROUND: begin
                if (!hold) begin
                    round_d = round_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                    if (round_q == LAST_FULL_RND) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                // Final round key is the last one; round and rcon stay put.
                if (!hold) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    round_d = 4'd0;
                    rcon_d  = RCON_FIRST;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd0;
                rcon_d  = RCON_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            rcon_q  <= RCON_FIRST;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE) & ~rst;
        ld_state   = (state_q == INIT) & ~hold;
        key_ld     = (state_q == INIT) & ~hold;
        rnd_en     = ((state_q == ROUND) | (state_q == FINAL)) & ~hold;
        key_en     = ((state_q == ROUND) | (state_q == FINAL)) & ~hold;
        mix_bypass = (state_q == FINAL) & ~hold;
        busy       = (state_q != IDLE);
        out_valid  = (state_q == DONE);
    end

    assign round = round_q;
    assign rcon  = rcon_q;

endmodule
